// File: rtl/video_acc_sequencer.sv
// Video accelerator sequencer: instruction FIFO, DMA base-address registers and a
// decoder FSM that issues read/write mover commands and waits for stream completion.
module video_acc_sequencer #(
  parameter int NR_FUN_UNITS = 2,
  parameter int DEST_WIDTH   = 3,
  parameter int FIFO_DEPTH   = 32,
  parameter int N_BASE       = 2,
  parameter int ADDR_WIDTH   = 64,
  localparam int PTR_W       = $clog2(FIFO_DEPTH),
  localparam int CNT_W       = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_w_valid,
  input  logic [31:0]           inst_w_data,
  output logic                  inst_w_ready,
  output logic [31:0]           inst_rd_data,
  output logic [CNT_W-1:0]      inst_count,
  output logic                  rd_cmd_valid,
  input  logic                  rd_cmd_ready,
  output logic [ADDR_WIDTH-1:0] rd_cmd_addr,
  output logic [12:0]           rd_cmd_len,
  output logic                  wr_cmd_valid,
  input  logic                  wr_cmd_ready,
  output logic [ADDR_WIDTH-1:0] wr_cmd_addr,
  output logic [DEST_WIDTH-1:0] route_dest,
  input  logic                  out_done,
  output logic                  busy,
  output logic                  done_pulse,
  output logic                  err_illegal,
  input  logic                  err_clear
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_LO, S_LOAD_HI, S_ISSUE, S_WAIT} state_e;

  localparam logic [5:0] OP_NOP       = 6'd0;
  localparam logic [5:0] OP_MOV       = 6'd1;
  localparam logic [5:0] OP_LOAD_FULL = 6'd2;
  localparam logic [5:0] OP_LOAD_LOW  = 6'd3;
  localparam logic [5:0] OP_EXEC0     = 6'd4;
  localparam logic [6:0] EXEC_END     = 7'(4 + NR_FUN_UNITS);
  localparam logic [2:0] N_BASE_L     = 3'(N_BASE);

  state_e                  state_q, state_d;
  logic [31:0]             mem_q [FIFO_DEPTH];
  logic [CNT_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0]   rd_base_q [N_BASE];
  logic [ADDR_WIDTH-1:0]   rd_base_d [N_BASE];
  logic [ADDR_WIDTH-1:0]   wr_base_q [N_BASE];
  logic [ADDR_WIDTH-1:0]   wr_base_d [N_BASE];
  logic                    ld_bank_q, ld_bank_d;
  logic [1:0]              ld_idx_q, ld_idx_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [12:0]             len_q, len_d;
  logic [DEST_WIDTH-1:0]   route_q, route_d;
  logic                    rd_vld_q, rd_vld_d, wr_vld_q, wr_vld_d;
  logic                    done_q, done_d, err_q, err_d;

  logic                    fifo_empty, fifo_full, push, pop, illegal_pop;
  logic [31:0]             head;
  logic [5:0]              opcode;
  logic                    is_exec;
  logic [ADDR_WIDTH-1:0]   cmd_rd_base, cmd_wr_base;
  logic                    tgt_bank, tgt_ok, base_we;
  logic [1:0]              tgt_idx;
  logic [ADDR_WIDTH-1:0]   tgt_cur, base_new;

  assign inst_count   = wr_ptr_q - rd_ptr_q;
  assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
  assign fifo_full    = (inst_count == CNT_W'(FIFO_DEPTH));
  assign inst_w_ready = ~fifo_full;
  assign head         = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign inst_rd_data = fifo_empty ? '0 : head;
  // A full FIFO still accepts a word in the cycle its head is popped.
  assign push         = inst_w_valid & (~fifo_full | pop);
  assign opcode       = head[5:0];
  assign is_exec      = (opcode >= OP_EXEC0) && ({1'b0, opcode} < EXEC_END);

  assign rd_cmd_valid = rd_vld_q;
  assign wr_cmd_valid = wr_vld_q;
  assign rd_cmd_addr  = rd_addr_q;
  assign wr_cmd_addr  = wr_addr_q;
  assign rd_cmd_len   = len_q;
  assign route_dest   = route_q;
  assign busy         = (state_q != S_IDLE) | ~fifo_empty;
  assign done_pulse   = done_q;
  assign err_illegal  = err_q;

  // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= inst_w_data;
  end

  // Base-pair selection; an out-of-range index falls back to pair 0.
  always_comb begin
    cmd_rd_base = rd_base_q[0];
    cmd_wr_base = wr_base_q[0];
    for (int i = 1; i < N_BASE; i++) begin
      if (head[28:27] == 2'(i)) cmd_rd_base = rd_base_q[i];
      if (head[30:29] == 2'(i)) cmd_wr_base = wr_base_q[i];
    end
  end

  always_comb begin
    if (state_q == S_IDLE) begin
      tgt_bank = head[27];
      tgt_idx  = head[29:28];
    end else begin
      tgt_bank = ld_bank_q;
      tgt_idx  = ld_idx_q;
    end
    tgt_ok  = ({1'b0, tgt_idx} < N_BASE_L);
    tgt_cur = tgt_bank ? wr_base_q[0] : rd_base_q[0];
    for (int i = 1; i < N_BASE; i++) begin
      if (tgt_idx == 2'(i)) tgt_cur = tgt_bank ? wr_base_q[i] : rd_base_q[i];
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_base_d   = rd_base_q;
    wr_base_d   = wr_base_q;
    ld_bank_d   = ld_bank_q;
    ld_idx_d    = ld_idx_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    len_d       = len_q;
    route_d     = route_q;
    rd_vld_d    = rd_vld_q;
    wr_vld_d    = wr_vld_q;
    done_d      = 1'b0;
    pop         = 1'b0;
    illegal_pop = 1'b0;
    base_we     = 1'b0;
    base_new    = tgt_cur;

    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (opcode == OP_NOP) begin
            state_d = S_IDLE;
          end else if (opcode == OP_LOAD_LOW) begin
            base_we        = tgt_ok;
            base_new[26:6] = head[26:6];
          end else if (opcode == OP_LOAD_FULL) begin
            ld_bank_d = head[27];
            ld_idx_d  = head[29:28];
            state_d   = S_LOAD_LO;
          end else if (opcode == OP_MOV || is_exec) begin
            rd_addr_d = cmd_rd_base + ADDR_WIDTH'({head[12:6], 6'b0});
            wr_addr_d = cmd_wr_base + ADDR_WIDTH'({head[19:13], 6'b0});
            len_d     = {head[26:20], 6'b0};
            route_d   = (opcode == OP_MOV) ? '0 : DEST_WIDTH'(opcode - 6'd3);
            if (head[26:20] == 7'd0) begin
              done_d = 1'b1;
            end else begin
              rd_vld_d = 1'b1;
              wr_vld_d = 1'b1;
              state_d  = S_ISSUE;
            end
          end else begin
            illegal_pop = 1'b1;
          end
        end
      end
      S_LOAD_LO: begin
        if (!fifo_empty) begin
          pop            = 1'b1;
          base_we        = tgt_ok;
          base_new[31:0] = {head[31:6], 6'b0};
          state_d        = S_LOAD_HI;
        end
      end
      S_LOAD_HI: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          base_we  = tgt_ok;
          base_new = ADDR_WIDTH'({head, tgt_cur[31:0]});
          state_d  = S_IDLE;
        end
      end
      S_ISSUE: begin
        rd_vld_d = rd_vld_q & ~rd_cmd_ready;
        wr_vld_d = wr_vld_q & ~wr_cmd_ready;
        if (!rd_vld_d && !wr_vld_d) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (out_done) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    for (int i = 0; i < N_BASE; i++) begin
      if (base_we && tgt_idx == 2'(i)) begin
        if (tgt_bank) wr_base_d[i] = base_new;
        else          rd_base_d[i] = base_new;
      end
    end

    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;

    err_d = err_q;
    if (err_clear)   err_d = 1'b0;
    if (illegal_pop) err_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_base_q <= '{default: '0};
      wr_base_q <= '{default: '0};
      ld_bank_q <= 1'b0;
      ld_idx_q  <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      len_q     <= '0;
      route_q   <= '0;
      rd_vld_q  <= 1'b0;
      wr_vld_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_base_q <= rd_base_d;
      wr_base_q <= wr_base_d;
      ld_bank_q <= ld_bank_d;
      ld_idx_q  <= ld_idx_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      len_q     <= len_d;
      route_q   <= route_d;
      rd_vld_q  <= rd_vld_d;
      wr_vld_q  <= wr_vld_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: doc/video_acc_sequencer.md
VIDEO_ACC_SEQUENCER -- requirements
Module: video_acc_sequencer

Interface
REQ-001 Parameter NR_FUN_UNITS, default 2: number of stream functional units, 1..6.
REQ-002 Parameter DEST_WIDTH, default 3: width of router destination select.
REQ-003 Parameter FIFO_DEPTH, default 32: instruction FIFO entries, power of 2, >=2.
REQ-004 Parameter N_BASE, default 2: base-address register pairs (rd and wr), 1..4.
REQ-005 Parameter ADDR_WIDTH, default 64: DMA address width, >=32.
REQ-006 Ports, one per line: name, direction, width, meaning.
  clk  in  1  the single clock.
  rst  in  1  reset; synchronous and active-high.
  inst_w_valid  in  1  instruction word write strobe.
  inst_w_data  in  32  instruction word.
  inst_w_ready  out  1  FIFO not full.
  inst_rd_data  out  32  FIFO head word, 0 when empty.
  inst_count  out  log2(FIFO_DEPTH)+1  FIFO occupancy.
  rd_cmd_valid / rd_cmd_ready  out/in  1  read-mover command handshake.
  rd_cmd_addr  out  ADDR_WIDTH  read source address.
  rd_cmd_len  out  13  read length, bytes.
  wr_cmd_valid / wr_cmd_ready  out/in  1  write-mover command handshake.
  wr_cmd_addr  out  ADDR_WIDTH  write destination address.
  route_dest  out  DEST_WIDTH  router destination for the current command.
  out_done  in  1  one-cycle pulse: final output beat accepted (t_valid & t_ready & t_last).
  busy  out  1  state not IDLE, or FIFO non-empty.
  done_pulse  out  1  one-cycle pulse when a command completes.
  err_illegal  out  1  sticky illegal-opcode flag.
  err_clear  in  1  clears err_illegal.

Function
REQ-007 Instruction fields: opcode [5:0], src [12:6], dest [19:13], len [26:20], attrib [31:27]; src/dest/len are in 64-byte units (field << 6).
REQ-008 Opcodes: NOP 0; MOV 1 (route 0); LOAD_FULL 2; LOAD_LOW 3; EXEC_k = 4+k for k < NR_FUN_UNITS (route k+1); all others illegal.
REQ-009 LOAD ops: attrib[0] selects bank (0 rd, 1 wr); attrib[2:1] selects pair index; an index >= N_BASE makes the load discarded with no error.
REQ-010 Command ops (MOV/EXEC): attrib[1:0] selects rd base, attrib[3:2] selects wr base; an index >= N_BASE selects pair 0.
REQ-011 FIFO push when inst_w_valid & inst_w_ready; a write while full is dropped; push and pop in the same cycle while full is legal, and occupancy stays unchanged.
REQ-012 No write-to-read bypass: a word pushed into an empty FIFO is decodable the following cycle.
REQ-013 FSM states: IDLE, LOAD_LO, LOAD_HI, ISSUE, WAIT.
REQ-014 IDLE with FIFO non-empty: always pop the head.
  NOP: stay in IDLE.
  LOAD_LOW: write head bits [26:6] into bits [26:6] of the selected base.
  LOAD_FULL: go to LOAD_LO.
  Illegal: set err_illegal.
  MOV/EXEC: latch addresses, len and route, then go to ISSUE.
REQ-015 LOAD_LO: when non-empty, pop; base[31:0] <= word with bits [5:0] cleared; go to LOAD_HI. LOAD_HI: when non-empty, pop; base[63:32] <= word (truncated to ADDR_WIDTH); go to IDLE. Both states hold while empty.
REQ-016 Command latch:
  rd_cmd_addr = rd_base + (src<<6), modulo 2^ADDR_WIDTH.
  wr_cmd_addr = wr_base + (dest<<6), modulo 2^ADDR_WIDTH.
  rd_cmd_len = len<<6.
  route_dest is set in the same cycle and held until the next command latch.
REQ-017 A command with len field 0 issues no mover commands, pulses done_pulse the next cycle, and returns to IDLE.
REQ-018 ISSUE: assert rd_cmd_valid and wr_cmd_valid from the first ISSUE cycle.
  Each valid drops the cycle after its own handshake.
  Payloads are stable while valid.
  Go to WAIT once both handshakes have completed, including same-cycle completion.
REQ-019 WAIT: on out_done, pulse done_pulse for one cycle and go to IDLE; the next instruction is decoded no earlier than the cycle after that. out_done in any other state is ignored.
REQ-020 err_illegal sets on an illegal pop and clears on err_clear; when both occur in the same cycle, set wins.

Reset
REQ-021 While rst is high at a clk edge:
  FIFO emptied.
  All bases zero.
  State IDLE.
  Every output 0; inst_w_ready is 1 on the cycle after reset.
REQ-022 Reset mid-command abandons the command: valids drop and no done_pulse is generated.

Verification
REQ-023 Write LOAD_FULL (attrib 0), 0x1234_5678, 0x0000_0001, then MOV src=2 dest=3 len=4 -> rd_cmd_addr 0x1_1234_56C0, wr_cmd_addr 0xC0, rd_cmd_len 256, route_dest 0.
REQ-024 EXEC_1 with rd_cmd_ready delayed 5 cycles and wr_cmd_ready immediate -> wr valid drops after 1 cycle, rd valid held 5 cycles; WAIT entered only after both; out_done -> single done_pulse; route_dest 2.
REQ-025 Fill FIFO_DEPTH words while the decoder is blocked in WAIT -> inst_w_ready=0 and inst_count=FIFO_DEPTH; the extra write is dropped; pushing during the pop cycle keeps the count at FIFO_DEPTH.
REQ-026 Opcode 0x3F followed by NOP -> err_illegal=1 and both words popped; err_clear -> 0; simultaneous illegal pop and err_clear -> stays 1.
REQ-027 Base at 0xFFFF_FFFF_FFFF_FFC0 with src=1 -> rd_cmd_addr wraps to 0; MOV with len=0 -> no valids, done_pulse after 1 cycle.
REQ-028 Assert rst during ISSUE -> valids 0 on the next cycle, inst_count 0, no done_pulse.
